// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port select,
// and the word-alignment mask.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE1 = 3'd2,
        ST_STROBE2 = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_t;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. The last-grant register only moves when the
// caller accepts the grant, so a tie always goes to the port not served last.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  req_if,
    input  logic  req_ls,
    input  logic  accept,
    output logic  grant_valid,
    output port_t grant
);

    port_t last;

    always_comb begin
        grant_valid = req_if | req_ls;
        grant       = PORT_IF;
        if (req_if && req_ls) begin
            grant = (last == PORT_LS) ? PORT_IF : PORT_LS;
        end else if (req_ls) begin
            grant = PORT_LS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= PORT_LS;
        end else if (accept && grant_valid) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises an instruction-fetch port and a load/store port onto one
// word-wide memory with a five-state strobe sequence per transaction.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ready,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_in,
    output logic              mem_read,
    output logic              mem_write,
    output state_t            dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

    state_t            state;
    port_t             grant;
    port_t             cur_port;
    logic              grant_valid;
    logic              cur_we;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              sel_bad;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req_if      (if_req),
        .req_ls      (ls_req),
        .accept      (state == ST_IDLE),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        sel_addr = (grant == PORT_LS) ? ls_addr : if_addr;
        sel_we   = (grant == PORT_LS) && ls_we;
        sel_bad  = ((sel_addr[1:0] & WORD_ALIGN_MASK) != 2'b00) || (sel_addr > LAST_WORD);
    end

    assign dbg_state = state;

    // Port inputs are only looked at in IDLE; everything after that runs
    // from the latched cur_port / cur_we / mem_addr / bus_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_port  <= PORT_LS;
            cur_we    <= 1'b0;
            mem_addr  <= '0;
            bus_out   <= '0;
            bus_oe    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if_ready  <= 1'b0;
            ls_ready  <= 1'b0;
            if_err    <= 1'b0;
            ls_err    <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        cur_port <= grant;
                        cur_we   <= sel_we;
                        if (sel_bad) begin
                            // Rejected requests skip the memory entirely.
                            state <= ST_RESP;
                            if (grant == PORT_LS) begin
                                ls_ready <= 1'b1;
                                ls_err   <= 1'b1;
                            end else begin
                                if_ready <= 1'b1;
                                if_err   <= 1'b1;
                            end
                        end else begin
                            state    <= ST_SETUP;
                            mem_addr <= sel_addr;
                            bus_oe   <= sel_we;
                            if (sel_we) begin
                                bus_out <= ls_wdata;
                            end
                        end
                    end
                end
                ST_SETUP: begin
                    state     <= ST_STROBE1;
                    mem_read  <= !cur_we;
                    mem_write <= cur_we;
                end
                ST_STROBE1: begin
                    state <= ST_STROBE2;
                end
                ST_STROBE2: begin
                    state     <= ST_RESP;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    bus_oe    <= 1'b0;
                    if (cur_port == PORT_LS) begin
                        ls_ready <= 1'b1;
                        if (!cur_we) begin
                            ls_rdata <= bus_in;
                        end
                    end else begin
                        if_ready <= 1'b1;
                        if_rdata <= bus_in;
                    end
                end
                ST_RESP: begin
                    state    <= ST_IDLE;
                    if_ready <= 1'b0;
                    ls_ready <= 1'b0;
                    if_err   <= 1'b0;
                    ls_err   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word memory on the bus side.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_ready;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic [31:0] mem_addr;
    logic [31:0] bus_out;
    logic        bus_oe;
    logic [31:0] bus_in;
    logic        mem_read;
    logic        mem_write;
    state_t      dbg_state;

    logic [31:0] mem_model [0:1023];
    logic        use_drive = 1'b0;
    logic [31:0] bus_drive = '0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(4096)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_ready  (ls_ready),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .mem_addr  (mem_addr),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .bus_in    (bus_in),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // memory on the far side of the bus
    always @(posedge clk) begin
        if (mem_write) begin
            mem_model[mem_addr[11:2]] <= bus_out;
        end
    end
    assign bus_in = use_drive ? bus_drive : mem_model[mem_addr[11:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst    = 1'b1;
        if_req = 1'b0;
        ls_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Legal transaction; req is dropped and the port inputs scrambled after
    // the grant, so the whole sequence must run from latched values.
    task automatic run_txn(input bit on_ls, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd);
        state_t exp_st;
        bit     strobe;
        if (on_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        tick();
        if_req = 1'b0; ls_req = 1'b0; ls_we = !we;
        if_addr = 32'h0000_0104; ls_addr = 32'h0000_0100; ls_wdata = 32'hBAD0_BAD0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            strobe = (c == 2) || (c == 3);
            case (c)
                1:       exp_st = ST_SETUP;
                2:       exp_st = ST_STROBE1;
                3:       exp_st = ST_STROBE2;
                4:       exp_st = ST_RESP;
                default: exp_st = ST_IDLE;
            endcase
            check("state", 32'(dbg_state), 32'(exp_st));
            if (c <= 4) check("mem_addr", mem_addr, addr);
            check("mem_read", 32'(mem_read), 32'(!we && strobe));
            check("mem_write", 32'(mem_write), 32'(we && strobe));
            check("bus_oe", 32'(bus_oe), 32'(we && c <= 3));
            if (we && c <= 3) check("bus_out", bus_out, wdata);
            check("if_ready", 32'(if_ready), 32'(!on_ls && c == 4));
            check("ls_ready", 32'(ls_ready), 32'(on_ls && c == 4));
            check("if_err", 32'(if_err), 32'h0);
            check("ls_err", 32'(ls_err), 32'h0);
            if (c == 4) check(on_ls ? "ls_rdata" : "if_rdata", on_ls ? ls_rdata : if_rdata, exp_rd);
        end
    endtask

    // Misaligned or out-of-range request: answered at cycle 1 with err.
    task automatic err_txn(input bit on_ls, input logic [31:0] addr, input logic [31:0] exp_rd);
        if (on_ls) begin
            ls_req = 1'b1; ls_we = 1'b0; ls_addr = addr;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        tick();
        if_req = 1'b0; ls_req = 1'b0;
        check("err_state", 32'(dbg_state), 32'(ST_RESP));
        check("err_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check("err_bus_oe", 32'(bus_oe), 32'h0);
        check("err_if_ready", 32'(if_ready), 32'(!on_ls));
        check("err_ls_ready", 32'(ls_ready), 32'(on_ls));
        check("err_if_err", 32'(if_err), 32'(!on_ls));
        check("err_ls_err", 32'(ls_err), 32'(on_ls));
        check("err_rdata", on_ls ? ls_rdata : if_rdata, exp_rd);
        tick();
        check("err_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("err_ready_clr", {30'h0, if_ready, ls_ready}, 32'h0);
        check("err_err_clr", {30'h0, if_err, ls_err}, 32'h0);
    endtask

    initial begin
        reset_dut();
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_strobes", {29'h0, mem_read, mem_write, bus_oe}, 32'h0);
        check("rst_ready", {30'h0, if_ready, ls_ready}, 32'h0);
        check("rst_err", {30'h0, if_err, ls_err}, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_ls_rdata", ls_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);

        // fetch read with a forced bus value; req dropped in SETUP
        use_drive = 1'b1; bus_drive = 32'hDEAD_BEEF;
        run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
        use_drive = 1'b0;

        // write then read back through both ports
        run_txn(1'b1, 1'b1, 32'h0000_0020, 32'h0000_00AA, 32'h0000_0000);
        run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_00AA);
        run_txn(1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_00AA);
        run_txn(1'b1, 1'b1, 32'h0000_0024, 32'h5555_1234, 32'h0000_00AA);
        run_txn(1'b1, 1'b0, 32'h0000_0024, 32'h0, 32'h5555_1234);

        // rejected addresses leave rdata alone
        err_txn(1'b1, 32'h0000_0022, 32'h5555_1234);
        err_txn(1'b1, 32'h0000_0FFD, 32'h5555_1234);
        err_txn(1'b1, 32'h0000_1000, 32'h5555_1234);
        err_txn(1'b0, 32'h0000_0013, 32'h0000_00AA);

        // last legal word
        use_drive = 1'b1; bus_drive = 32'h1234_5678;
        run_txn(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 32'h1234_5678);
        use_drive = 1'b0;

        // reset during STROBE1 of a write
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0040; ls_wdata = 32'h0000_0077;
        tick();
        ls_req = 1'b0;
        tick();
        check("mid_state", 32'(dbg_state), 32'(ST_STROBE1));
        check("mid_write", 32'(mem_write), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        check("abort_strobes", {29'h0, mem_read, mem_write, bus_oe}, 32'h0);
        check("abort_mem_addr", mem_addr, 32'h0);
        check("abort_ls_rdata", ls_rdata, 32'h0);
        check("abort_if_rdata", if_rdata, 32'h0);
        for (int c = 0; c < 5; c++) begin
            check("abort_no_ready", {30'h0, if_ready, ls_ready}, 32'h0);
            tick();
        end

        // both ports held high from reset: IF, LS, IF, LS, 5 cycles apart
        reset_dut();
        if_req = 1'b1; if_addr = 32'h0000_0020;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0024;
        for (int c = 1; c <= 19; c++) begin
            tick();
            check("rr_if_ready", 32'(if_ready), 32'(c == 4 || c == 14));
            check("rr_ls_ready", 32'(ls_ready), 32'(c == 9 || c == 19));
            check("rr_excl", 32'(mem_read && mem_write), 32'h0);
            if (c == 4) check("rr_if_rdata", if_rdata, 32'h0000_00AA);
            if (c == 9) check("rr_ls_rdata", ls_rdata, 32'h5555_1234);
        end
        if_req = 1'b0; ls_req = 1'b0;
        tick();
        tick();
        check("rr_end_idle", 32'(dbg_state), 32'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width in bits.
REQ-002 Parameter DATA_W, 32, data word width in bits.
REQ-003 Parameter MEM_BYTES, 4096, size of the attached byte-addressed memory.
REQ-004 clk  input  1  single clock; all state changes on the posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 if_req / if_addr / if_ready / if_rdata / if_err  in / in / out / out / out  1 / ADDR_W / 1 / DATA_W / 1  instruction-fetch port, read-only.
REQ-007 ls_req / ls_we / ls_addr / ls_wdata  in  1 / 1 / ADDR_W / DATA_W  load/store port request; ls_we=1 selects write.
REQ-008 ls_ready / ls_rdata / ls_err  out  1 / DATA_W / 1  load/store port response.
REQ-009 mem_addr  out  ADDR_W  address to the memory.
REQ-010 bus_out / bus_oe / bus_in  out / out / in  DATA_W / 1 / DATA_W  shared data bus; top level builds the tristate.
REQ-011 mem_read / mem_write  out  1 / 1  memory strobes.

Function
REQ-012 The block SHALL serialise both ports onto the single memory, one word transaction at a time.
REQ-013 FSM states SHALL be IDLE, SETUP, STROBE1, STROBE2, RESP.
- IDLE: pick a requester if any; else stay.
- SETUP: address/data driven, strobes low.
- STROBE1, STROBE2: strobe high.
- RESP: strobes low; ready pulse; return to IDLE.
REQ-014 Arbitration SHALL be round-robin: if both requests are high in IDLE, grant the port not granted last; a single request is granted immediately.
REQ-015 After reset, the last-grant pointer SHALL equal the ls port, so the fetch port wins the first tie.
REQ-016 The address, we and wdata of the granted port SHALL be latched on the IDLE->SETUP edge; later changes on the port inputs SHALL be ignored until RESP.
REQ-017 mem_addr SHALL be held stable from SETUP through RESP inclusive.
REQ-018 Writes:
- bus_oe=1 and bus_out=latched wdata from SETUP through STROBE2.
- mem_write=1 in STROBE1 and STROBE2 only.
REQ-019 Reads:
- bus_oe=0 in all states.
- mem_read=1 in STROBE1 and STROBE2 only.
- bus_in sampled into the rdata register at the end of STROBE2.
REQ-020 mem_read and mem_write SHALL never both be 1; bus_oe SHALL never be 1 during a read.
REQ-021 Latency: request seen in IDLE at cycle 0 -> granted port ready=1 for exactly one cycle at cycle 4 (RESP).
REQ-022 rdata SHALL be valid in the RESP cycle and held until the next read on that port; writes leave the port's rdata unchanged.
REQ-023 The ungranted port's ready SHALL stay 0.
REQ-024 Misaligned requests (addr[1:0]!=0) and out-of-range requests (addr > MEM_BYTES-4):
- no strobes asserted; FSM goes IDLE->RESP directly.
- ready=1 and err=1 at cycle 1; rdata unchanged.
REQ-025 err SHALL be 0 whenever ready is 0 and for all legal transactions.
REQ-026 Dropping req after grant SHALL NOT abort the transaction; it completes and still pulses ready.
REQ-027 A request held high through RESP SHALL be re-arbitrated in the next IDLE cycle as a new transaction (back-to-back throughput: one word per 5 cycles).
REQ-028 A port never granted while the other requests continuously SHALL be granted within 2 transactions.

Reset
REQ-029 When rst=1 at a posedge, the block SHALL enter IDLE; it SHALL clear mem_read, mem_write, bus_oe, both ready, both err, both rdata registers and mem_addr to 0; it SHALL set last-grant to ls.
REQ-030 Reset mid-transaction SHALL drop all strobes at that same edge, with no ready pulse for the aborted transaction.
REQ-031 Reset SHALL take priority over all other state updates.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the port-select enum (IF, LS) and the word-alignment mask constant.
REQ-033 One sub-module, rr_arbiter2 (two-way round-robin grant with last-grant register), SHALL be instantiated; the rest is flat.

Verification
REQ-034 if_req=1, if_addr=0x10, bus_in=0xDEADBEEF -> mem_read=1 in cycles 2-3, if_ready=1 with if_rdata=0xDEADBEEF in cycle 4.
REQ-035 ls write 0x0000_00AA to 0x20 -> bus_oe=1 cycles 1-3, mem_write=1 cycles 2-3, ls_ready cycle 4; read-back of 0x20 returns 0xAA.
REQ-036 if_req and ls_req both high from reset -> grant order IF, LS, IF, LS; each ready pulse is 1 cycle, 5 cycles apart.
REQ-037 ls_addr=0x22 or ls_addr=0xFFD -> no strobes, ls_ready=1 with ls_err=1 at cycle 1.
REQ-038 rst asserted during STROBE1 of a write -> mem_write=0 and FSM in IDLE next cycle, no ls_ready pulse.
REQ-039 if_req dropped in SETUP -> transaction completes, if_ready pulses at cycle 4.
